// File: rtl/button_events_pkg.sv
// Shared event codes, per-button state encodings and small helpers for button_events.
// Imported by button_fsm and button_events.
package button_events_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_kind_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    LONGHELD = 2'd2
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Within one button: PRESS, LONG, REPEAT, then RELEASE
  function automatic evt_kind_e pick_kind(input logic [3:0] p);
    evt_kind_e k;
    if (p[EVT_PRESS])
      k = EVT_PRESS;
    else if (p[EVT_LONG])
      k = EVT_LONG;
    else if (p[EVT_REPEAT])
      k = EVT_REPEAT;
    else
      k = EVT_RELEASE;
    return k;
  endfunction

endpackage

// File: rtl/button_events_fsm.sv
// button_fsm: per-button synchronizer, press/hold FSM, hold timer and pending bits.
// Ports:
//   clk, reset     clock, async active-high reset
//   btn            debounced button level (async)
//   base_load      load state from current level without events
//   en             baseline done, FSM may emit events
//   tick           hold timer advance strobe
//   clr            per-kind pending clear (handshake)
//   held           synchronized pressed state
//   pend_nxt       next value of the pending bits
//   drop           an event was lost because its bit was already pending
// AUTOREPEAT_EN: when defined LONGHELD emits REPEAT every REPEAT_TICKS.
module button_fsm
  import button_events_pkg::*;
#(
  parameter int PRESS_LEVEL  = 0,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn,
  input  logic       base_load,
  input  logic       en,
  input  logic       tick,
  input  logic [3:0] clr,
  output logic       held,
  output logic [3:0] pend_nxt,
  output logic       drop
);

  localparam int TSAT = max_int(LONG_TICKS, REPEAT_TICKS);
  localparam int TW   = $clog2(TSAT + 1);
  localparam logic PL = (PRESS_LEVEL != 0);

  localparam logic [TW-1:0] T_SAT  = TW'(TSAT);
  localparam logic [TW-1:0] T_LONG = TW'(LONG_TICKS);
`ifdef AUTOREPEAT_EN
  localparam logic [TW-1:0] T_REP  = TW'(REPEAT_TICKS);
`endif

  logic          s1;
  logic          s2;
  btn_state_e    st;
  logic [TW-1:0] tmr;
  logic [TW-1:0] t_inc;
  logic [3:0]    pend;
  logic [3:0]    set;

  assign held  = (s2 == PL);

  // Saturating increment: the timer never wraps
  assign t_inc = (tmr >= T_SAT) ? tmr : tmr + TW'(1);

  // A release always takes precedence over a tick in the same cycle
  always_comb begin
    set = '0;
    if (en) begin
      unique case (st)
        IDLE: begin
          set[EVT_PRESS] = held;
        end
        PRESSED: begin
          set[EVT_RELEASE] = ~held;
          set[EVT_LONG]    = held & tick & (t_inc == T_LONG);
        end
        LONGHELD: begin
          set[EVT_RELEASE] = ~held;
`ifdef AUTOREPEAT_EN
          set[EVT_REPEAT]  = held & tick & (t_inc == T_REP);
`endif
        end
        default: ;
      endcase
    end
  end

  // A bit set and cleared together stays set: the new event is kept
  assign pend_nxt = (pend & ~clr) | set;
  assign drop     = |(set & pend & ~clr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= ~PL;
      s2   <= ~PL;
      st   <= IDLE;
      tmr  <= '0;
      pend <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      pend <= pend_nxt;
      if (base_load) begin
        st  <= held ? PRESSED : IDLE;
        tmr <= '0;
      end else if (en) begin
        unique case (st)
          IDLE: begin
            if (held) begin
              st  <= PRESSED;
              tmr <= '0;
            end
          end
          PRESSED: begin
            if (!held)
              st <= IDLE;
            else if (set[EVT_LONG]) begin
              st  <= LONGHELD;
              tmr <= '0;
            end else if (tick)
              tmr <= t_inc;
          end
          LONGHELD: begin
            if (!held)
              st <= IDLE;
`ifdef AUTOREPEAT_EN
            else if (set[EVT_REPEAT])
              tmr <= '0;
`endif
            else if (tick)
              tmr <= t_inc;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/button_events.sv
// button_events: turns N debounced button levels into PRESS/RELEASE/LONG/REPEAT
// events on a registered valid/ready stream, lowest button index first.
// Ports:
//   clk        system clock
//   reset      async active-high reset
//   btn_in     debounced button levels (async)
//   evt_valid  event presented
//   evt_ready  consumer accepts on evt_valid & evt_ready
//   evt_btn    button index of the presented event
//   evt_kind   0=PRESS 1=RELEASE 2=LONG 3=REPEAT
//   held       synchronized pressed state per button
//   overflow   sticky, an event was lost
// AUTOREPEAT_EN: when defined, REPEAT events are generated after LONG.
module button_events
  import button_events_pkg::*;
#(
  parameter int N            = 4,
  parameter int PRESS_LEVEL  = 0,
  parameter int TICK_DIV     = 50000,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [3:0]   evt_btn,
  output logic [1:0]   evt_kind,
  output logic [N-1:0] held,
  output logic         overflow
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div;
  logic          tick;

  assign tick = (div == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div <= '0;
    else
      div <= tick ? DW'(TICK_DIV - 1) : div - DW'(1);
  end

  // Synchronizer output is meaningful two cycles after reset
  logic [1:0] vld;
  logic       base_done;
  logic       base_load;

  assign base_load = vld[1] & ~base_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld       <= '0;
      base_done <= 1'b0;
    end else begin
      vld <= {vld[0], 1'b1};
      if (base_load)
        base_done <= 1'b1;
    end
  end

  logic         hs;
  logic [3:0]   pnx [N];
  logic [3:0]   clr [N];
  logic [N-1:0] drop;

  assign hs = evt_valid & evt_ready;

  for (genvar i = 0; i < N; i++) begin : g_btn
    assign clr[i] = (hs && evt_btn == 4'(i))
                  ? (4'b0001 << evt_kind) : 4'b0000;

    button_fsm #(
      .PRESS_LEVEL (PRESS_LEVEL),
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS)
    ) u_fsm (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn_in[i]),
      .base_load(base_load),
      .en       (base_done),
      .tick     (tick),
      .clr      (clr[i]),
      .held     (held[i]),
      .pend_nxt (pnx[i]),
      .drop     (drop[i])
    );
  end

  // Scan high to low so the lowest pending index wins
  logic       sel_v;
  logic [3:0] sel_b;
  evt_kind_e  sel_k;

  always_comb begin
    sel_v = 1'b0;
    sel_b = '0;
    sel_k = EVT_PRESS;
    for (int i = N - 1; i >= 0; i--) begin
      if (|pnx[i]) begin
        sel_v = 1'b1;
        sel_b = 4'(i);
        sel_k = pick_kind(pnx[i]);
      end
    end
  end

  // After a handshake valid drops for one cycle, so the cleared bit
  // can never be presented twice; ready never feeds valid directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_btn   <= '0;
      evt_kind  <= EVT_PRESS;
      overflow  <= 1'b0;
    end else begin
      overflow <= overflow | (|drop);
      if (hs)
        evt_valid <= 1'b0;
      else if (!evt_valid) begin
        evt_valid <= sel_v;
        if (sel_v) begin
          evt_btn  <= sel_b;
          evt_kind <= sel_k;
        end
      end
    end
  end

endmodule
